muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Sequences the multi-cycle Mult and Div units on behalf of the main control unit.
- Accepts one MULT/DIV request at a time and issues a single-cycle start pulse to the selected unit.
- Waits for that unit's completion, then drives the hi/lo source select and the HI/LO load enables.
- Reports completion, divide-by-zero and watchdog timeout to the control unit, so its FSM only needs a request/done handshake instead of per-unit wait states.

Parameters:
- TIMEOUT, 48, maximum WAIT cycles before the operation is aborted; must be ≥2 and < 2^CNT_W.
- CNT_W, 6, width of the wait counter and of last_latency.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  operation request; sampled only in IDLE.
- is_div  in  1  operation type at accept: 1=DIV, 0=MULT.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle completion pulse (normal or aborted).
- div_zero  out  1  one-cycle pulse, coincident with done, when DIV aborted on divide-by-zero.
- timeout  out  1  one-cycle pulse, coincident with done, when the watchdog expired.
- mult_start  out  1  one-cycle start pulse to the Mult unit.
- div_start  out  1  one-cycle start pulse to the Div unit.
- mult_end  in  1  Mult unit completion.
- div_end  in  1  Div unit completion.
- div_0_exception  in  1  Div unit divide-by-zero flag.
- div_or_mult  out  1  hi/lo source select: 0=Div outputs, 1=Mult outputs.
- high_write  out  1  HI register load enable.
- low_write  out  1  LO register load enable.
- last_latency  out  CNT_W  WAIT-cycle count of the last successful operation.

Behaviour:

Interface:
- One clock, `clock`.
- `reset` is synchronous and active-high.

Reset:
- State goes to IDLE.
- All outputs are 0, including div_or_mult, last_latency and the internal counter.
- Reset mid-operation aborts the operation: no HI/LO write and no done pulse.

States and outputs (Moore, all outputs decoded from registered state/flags):
- IDLE:
  - busy=0.
  - If req=1: latch op_div<=is_div, div_or_mult<=~is_div, cnt<=0, go to START.
- START (1 cycle):
  - busy=1.
  - mult_start=~op_div, div_start=op_div; exactly one start is high.
  - Go to WAIT.
- WAIT:
  - busy=1.
  - Each cycle, cnt<=cnt+1.
  - Only the selected unit's end/exception is examined; the other unit's end is ignored.
  - Priority, highest first:
    1. op_div & div_0_exception → EXC_DZ.
    2. selected end → WRITE; last_latency<=cnt+1.
    3. cnt==TIMEOUT-1 → EXC_TO.
    4. Otherwise stay in WAIT.
- WRITE (1 cycle):
  - busy=1, high_write=1, low_write=1.
  - div_or_mult held stable.
  - Go to DONE.
- DONE (1 cycle):
  - busy=0, done=1.
  - Go to IDLE; req is ignored this cycle.
- EXC_DZ (1 cycle):
  - done=1, div_zero=1, busy=0, no HI/LO write.
  - last_latency unchanged.
  - Go to IDLE.
- EXC_TO (1 cycle):
  - done=1, timeout=1, busy=0, no HI/LO write.
  - last_latency unchanged.
  - Go to IDLE.

Timing:
- Latency from req accept (IDLE edge) to done = end arrival cycle + 3 (START, WRITE, DONE).
- Minimum is 4 cycles when end is seen in the first WAIT cycle.
- End/exception inputs during IDLE, START, WRITE, DONE and EXC states are ignored.
- req held high back-to-back gives a new accept in the IDLE cycle following DONE.
- div_or_mult keeps its last value in IDLE; it changes only on accept.
- The counter never wraps, because TIMEOUT < 2^CNT_W.

Test Plan:
- MULT: req=1, is_div=0; mult_end asserted on 33rd WAIT cycle → exactly one mult_start pulse, no div_start; high_write=low_write=1 for one cycle with div_or_mult=1; done pulse next cycle; last_latency=33; busy=0 in DONE.
- DIV normal: is_div=1, div_end on 3rd WAIT cycle → div_start pulse, div_or_mult=0 during WRITE, last_latency=3, done 6 cycles after accept.
- DIV by zero: is_div=1; div_0_exception and div_end both high on 2nd WAIT cycle → done=1, div_zero=1 same cycle; high_write/low_write never asserted; last_latency keeps the previous value 3.
- Timeout: TIMEOUT=48, is_div=0, mult_end never asserted → after 48 WAIT cycles, done=1, timeout=1, no HI/LO write; then IDLE with busy=0.
- Stray/ignored events:
  - MULT in WAIT with div_end and div_0_exception pulsed → no effect; completes on mult_end.
  - req toggled while busy → no second start pulse.
  - req held high → second accept the cycle after DONE.
- Reset mid-WAIT: reset=1 for 1 cycle on 5th WAIT cycle → next cycle IDLE; all outputs 0, including last_latency; a late mult_end produces no write and no done.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Request/done channel between the control unit and the sequencer, plus the
// start/end/load strobes toward the Mult and Div units and the HI/LO registers.
`timescale 1ns/1ps

interface muldiv_sequencer_if #(
    parameter int CNT_W = 6
);
    // Handshake: req is sampled only while busy=0 and not in the done cycle; an
    // accepted op raises busy from START through WRITE, then ends with exactly one
    // done pulse (div_zero/timeout ride on that same pulse when it is an abort).
    logic             req;
    logic             is_div;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             timeout;
    logic             mult_start;
    logic             div_start;
    logic             mult_end;
    logic             div_end;
    logic             div_0_exception;
    logic             div_or_mult;
    logic             high_write;
    logic             low_write;
    logic [CNT_W-1:0] last_latency;
    logic [2:0]       state_dbg;

    modport master (
        output req, is_div, mult_end, div_end, div_0_exception,
        input  busy, done, div_zero, timeout, mult_start, div_start,
               div_or_mult, high_write, low_write, last_latency, state_dbg
    );

    modport slave (
        input  req, is_div, mult_end, div_end, div_0_exception,
        output busy, done, div_zero, timeout, mult_start, div_start,
               div_or_mult, high_write, low_write, last_latency, state_dbg
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Runs one MULT/DIV at a time: start pulse, bounded wait for the selected unit,
// HI/LO load, then a single done pulse (or an abort on divide-by-zero/watchdog).
`timescale 1ns/1ps

module muldiv_sequencer #(
    parameter int TIMEOUT = 48,
    parameter int CNT_W   = 6
) (
    input logic                clock,
    input logic                reset,
    muldiv_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_EXC_DZ = 3'd5,
        S_EXC_TO = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             op_div;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_latency;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             timeout;
    logic             mult_start;
    logic             div_start;
    logic             div_or_mult;
    logic             high_write;
    logic             low_write;
    logic             sel_end;

    // The unit that was not started may toggle its end freely; it is never looked at.
    assign sel_end = op_div ? bus.div_end : bus.mult_end;

    // Outputs are registered alongside the state so each one is valid exactly
    // during the state it belongs to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            op_div       <= 1'b0;
            cnt          <= '0;
            last_latency <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_zero     <= 1'b0;
            timeout      <= 1'b0;
            mult_start   <= 1'b0;
            div_start    <= 1'b0;
            div_or_mult  <= 1'b0;
            high_write   <= 1'b0;
            low_write    <= 1'b0;
        end else begin
            done       <= 1'b0;
            div_zero   <= 1'b0;
            timeout    <= 1'b0;
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            high_write <= 1'b0;
            low_write  <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (bus.req) begin
                        state       <= S_START;
                        op_div      <= bus.is_div;
                        div_or_mult <= ~bus.is_div;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        mult_start  <= ~bus.is_div;
                        div_start   <= bus.is_div;
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                    busy  <= 1'b1;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (op_div && bus.div_0_exception) begin
                        state    <= S_EXC_DZ;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                    end else if (sel_end) begin
                        state        <= S_WRITE;
                        last_latency <= cnt + 1'b1;
                        high_write   <= 1'b1;
                        low_write    <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_EXC_TO;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.div_zero     = div_zero;
    assign bus.timeout      = timeout;
    assign bus.mult_start   = mult_start;
    assign bus.div_start    = div_start;
    assign bus.div_or_mult  = div_or_mult;
    assign bus.high_write   = high_write;
    assign bus.low_write    = low_write;
    assign bus.last_latency = last_latency;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed and randomized operations compared with an
// outcome model (which event wins, when done fires, what last_latency becomes).
`timescale 1ns/1ps

module tb_muldiv_sequencer;
    localparam int TIMEOUT = 48;
    localparam int CNT_W   = 6;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    muldiv_sequencer_if #(.CNT_W(CNT_W)) bus ();

    muldiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_lat;
    logic [CNT_W-1:0] exp_q[$];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.req = 1'b0;
        bus.is_div = 1'b0;
        bus.mult_end = 1'b0;
        bus.div_end = 1'b0;
        bus.div_0_exception = 1'b0;
    endtask

    // Caller is in an IDLE cycle (cycle 0). end_at/dz_at name the WAIT cycle (1-based)
    // in which the event is presented; 0 means never. Returns in the IDLE cycle after done.
    task automatic do_op(input logic is_div, input int end_at, input int dz_at,
                         input bit stray, input bit hold_req, output int done_c);
        int kind, waits, exp_done, c, ms, ds, wr, wr_bad, dom_bad, busy_bad, flag_bad;
        bit seen_done;
        logic dz_obs, to_obs, busy_obs;
        logic [CNT_W-1:0] want_lat;
        // Outcome model: divide-by-zero beats a same-cycle end, end beats the watchdog.
        if (is_div && dz_at != 0 && dz_at <= TIMEOUT && (end_at == 0 || dz_at <= end_at)) begin
            kind = 1; waits = dz_at;
        end else if (end_at != 0 && end_at <= TIMEOUT) begin
            kind = 0; waits = end_at;
        end else begin
            kind = 2; waits = TIMEOUT;
        end
        exp_done = waits + ((kind == 0) ? 3 : 2);
        if (kind == 0) exp_lat = CNT_W'(waits);
        exp_q.push_back(exp_lat);

        ms = 0; ds = 0; wr = 0; wr_bad = 0; dom_bad = 0; busy_bad = 0; flag_bad = 0;
        c = 0; seen_done = 0; done_c = -1;
        dz_obs = 1'b0; to_obs = 1'b0; busy_obs = 1'b1;
        bus.req = 1'b1;
        bus.is_div = is_div;
        bus.mult_end = 1'b0;
        bus.div_end = 1'b0;
        bus.div_0_exception = 1'b0;
        while (!seen_done && c < TIMEOUT + 8) begin
            step();
            c++;
            ms += int'(bus.mult_start);
            ds += int'(bus.div_start);
            if (bus.high_write || bus.low_write) begin
                wr++;
                if (!(bus.high_write && bus.low_write)) wr_bad++;
            end
            if (bus.div_or_mult !== ~is_div) dom_bad++;
            if (bus.done === 1'b1) begin
                seen_done = 1;
                done_c = c;
                dz_obs = bus.div_zero;
                to_obs = bus.timeout;
                busy_obs = bus.busy;
            end else begin
                if (bus.busy !== 1'b1) busy_bad++;
                if (bus.div_zero || bus.timeout) flag_bad++;
            end
            bus.req = hold_req ? 1'b1 : ((stray && !seen_done) ? 1'($urandom_range(0, 1)) : 1'b0);
            if (seen_done) begin
                bus.mult_end = 1'b0;
                bus.div_end = 1'b0;
                bus.div_0_exception = 1'b0;
            end else if (is_div) begin
                bus.mult_end = stray ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.div_end = (end_at != 0 && c == end_at + 1) || (stray && c == 1);
                bus.div_0_exception = (dz_at != 0 && c == dz_at + 1);
            end else begin
                bus.mult_end = (end_at != 0 && c == end_at + 1) || (stray && c == 1);
                bus.div_end = stray ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.div_0_exception = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        checks++; if (!seen_done) begin failures++; $display("FAIL done_seen: no done within %0d cycles", c); end
        checks++; if (done_c != exp_done) begin failures++; $display("FAIL done_cycle: got %0d expected %0d", done_c, exp_done); end
        checks++; if (ms != (is_div ? 0 : 1)) begin failures++; $display("FAIL mult_start_count: got %0d expected %0d", ms, is_div ? 0 : 1); end
        checks++; if (ds != (is_div ? 1 : 0)) begin failures++; $display("FAIL div_start_count: got %0d expected %0d", ds, is_div ? 1 : 0); end
        checks++; if (wr != ((kind == 0) ? 1 : 0)) begin failures++; $display("FAIL write_count: got %0d expected %0d", wr, (kind == 0) ? 1 : 0); end
        checks++; if (wr_bad != 0) begin failures++; $display("FAIL write_pair: got %0d split writes expected 0", wr_bad); end
        checks++; if (dom_bad != 0) begin failures++; $display("FAIL div_or_mult: got %0d bad cycles expected 0", dom_bad); end
        checks++; if (busy_bad != 0) begin failures++; $display("FAIL busy_inflight: got %0d low cycles expected 0", busy_bad); end
        checks++; if (flag_bad != 0) begin failures++; $display("FAIL stray_flags: got %0d cycles expected 0", flag_bad); end
        checks++; if (dz_obs !== (kind == 1)) begin failures++; $display("FAIL div_zero: got %0b expected %0b", dz_obs, kind == 1); end
        checks++; if (to_obs !== (kind == 2)) begin failures++; $display("FAIL timeout: got %0b expected %0b", to_obs, kind == 2); end
        checks++; if (busy_obs !== 1'b0) begin failures++; $display("FAIL busy_at_done: got %0b expected 0", busy_obs); end
        bus.req = hold_req;
        step();
        want_lat = exp_q.pop_front();
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL post_idle: got busy=%0b done=%0b expected 0 0", bus.busy, bus.done); end
        checks++; if (bus.last_latency !== want_lat) begin failures++; $display("FAIL last_latency: got %0d expected %0d", bus.last_latency, want_lat); end
    endtask

    task automatic test_reset();
        quiet_inputs();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        exp_lat = '0;
        checks++; if ({bus.busy, bus.done, bus.div_zero, bus.timeout, bus.mult_start, bus.div_start} !== 6'b0) begin
            failures++; $display("FAIL reset_pulses: got %06b expected 000000",
                {bus.busy, bus.done, bus.div_zero, bus.timeout, bus.mult_start, bus.div_start}); end
        checks++; if ({bus.div_or_mult, bus.high_write, bus.low_write} !== 3'b0) begin
            failures++; $display("FAIL reset_hilo: got %03b expected 000", {bus.div_or_mult, bus.high_write, bus.low_write}); end
        checks++; if (bus.last_latency !== '0) begin failures++; $display("FAIL reset_latency: got %0d expected 0", bus.last_latency); end
    endtask

    task automatic test_mult();
        int dc;
        do_op(1'b0, 33, 0, 1'b0, 1'b0, dc);
    endtask

    task automatic test_div_normal();
        int dc;
        do_op(1'b1, 3, 0, 1'b0, 1'b0, dc);
        checks++; if (dc != 6) begin failures++; $display("FAIL div_done_at_6: got %0d expected 6", dc); end
    endtask

    task automatic test_div_zero();
        int dc;
        do_op(1'b1, 2, 2, 1'b0, 1'b0, dc);
        checks++; if (bus.last_latency !== CNT_W'(3)) begin failures++; $display("FAIL dz_keeps_latency: got %0d expected 3", bus.last_latency); end
    endtask

    task automatic test_timeout();
        int dc;
        do_op(1'b0, 0, 0, 1'b0, 1'b0, dc);
        checks++; if (dc != TIMEOUT + 2) begin failures++; $display("FAIL timeout_cycle: got %0d expected %0d", dc, TIMEOUT + 2); end
    endtask

    task automatic test_stray();
        int dc;
        do_op(1'b0, 10, 0, 1'b1, 1'b0, dc);
        do_op(1'b1, 7, 0, 1'b1, 1'b0, dc);
    endtask

    task automatic test_back_to_back();
        int dc;
        do_op(1'b0, 4, 0, 1'b0, 1'b1, dc);
        do_op(1'b1, 1, 0, 1'b0, 1'b1, dc);
        checks++; if (dc != 4) begin failures++; $display("FAIL min_latency: got %0d expected 4", dc); end
        do_op(1'b0, 2, 0, 1'b0, 1'b0, dc);
    endtask

    task automatic test_reset_mid_wait();
        int bad;
        bus.req = 1'b1;
        bus.is_div = 1'b0;
        step();
        bus.req = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_lat = '0;
        checks++; if ({bus.busy, bus.done, bus.div_or_mult, bus.high_write, bus.low_write, bus.mult_start} !== 6'b0) begin
            failures++; $display("FAIL midreset_outputs: got %06b expected 000000",
                {bus.busy, bus.done, bus.div_or_mult, bus.high_write, bus.low_write, bus.mult_start}); end
        checks++; if (bus.last_latency !== '0) begin failures++; $display("FAIL midreset_latency: got %0d expected 0", bus.last_latency); end
        bad = 0;
        bus.mult_end = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 2) bus.mult_end = 1'b0;
            if (bus.done || bus.high_write || bus.low_write || bus.busy) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL late_end_ignored: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_random();
        int dc, end_at, dz_at;
        logic is_div;
        for (int n = 0; n < 24; n++) begin
            is_div = 1'($urandom_range(0, 1));
            end_at = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            dz_at = (is_div && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, TIMEOUT)) : 0;
            do_op(is_div, end_at, dz_at, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dc);
        end
        bus.req = 1'b0;
        step();
        step();
    endtask

    initial begin
        reset = 1'b1;
        quiet_inputs();
        test_reset();
        test_mult();
        test_div_normal();
        test_div_zero();
        test_timeout();
        test_stray();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
